// File: rtl/param_service_unit_pkg.sv
// Shared definitions for the parameter service unit: register map, ACK layout and FSM states.
package param_service_unit_pkg;

    localparam logic [31:0] OFF_ENABLE  = 32'h00;
    localparam logic [31:0] OFF_PENDING = 32'h04;
    localparam logic [31:0] OFF_ACK     = 32'h08;
    localparam logic [31:0] OFF_MODE    = 32'h0C;
    localparam logic [31:0] OFF_SET     = 32'h10;
    localparam logic [31:0] OFF_CLEAR   = 32'h14;

    localparam int ACK_VLD_BIT = 31;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVING = 1'b1
    } psu_state_e;

    typedef enum logic [2:0] {
        REG_ENABLE,
        REG_PENDING,
        REG_ACK,
        REG_MODE,
        REG_SET,
        REG_CLEAR,
        REG_NONE
    } psu_reg_e;

    // Exact word-offset match; unaligned or out-of-map addresses decode to REG_NONE.
    function automatic psu_reg_e decode_reg(input logic [31:0] addr);
        case (addr)
            OFF_ENABLE:  return REG_ENABLE;
            OFF_PENDING: return REG_PENDING;
            OFF_ACK:     return REG_ACK;
            OFF_MODE:    return REG_MODE;
            OFF_SET:     return REG_SET;
            OFF_CLEAR:   return REG_CLEAR;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/psu_prio_encoder.sv
// Highest-index priority encoder: reports the topmost set request line and whether any is set.
module psu_prio_encoder #(
    parameter int NUM_LINES = 32,
    parameter int ID_W      = 5
) (
    input  logic [NUM_LINES-1:0] req_i,
    output logic [ID_W-1:0]      id_o,
    output logic                 valid_o
);

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        id_o = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (req_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/param_service_unit.sv
// APB-mapped event service unit: latches enabled line events as pending bits and
// hands them to software one at a time, highest line first, through a read-to-clear ACK.
module param_service_unit
    import param_service_unit_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int ID_W           = 5
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      signal_i,
    output logic                      irq_o
);

    logic [NUM_LINES-1:0] enable_q;
    logic [NUM_LINES-1:0] mode_q;
    logic [NUM_LINES-1:0] pending_q;
    logic [NUM_LINES-1:0] pending_d;
    logic [NUM_LINES-1:0] sig_q;
    psu_state_e           state_q;
    logic [ID_W-1:0]      ack_id_q;

    logic                 access;
    psu_reg_e             reg_sel;
    logic                 bad_access;
    logic                 wr_en;
    logic                 rd_en;
    logic                 ack_read;
    logic [31:0]          ack_word;
    logic [31:0]          rdata;
    logic [NUM_LINES-1:0] wdata;
    logic [NUM_LINES-1:0] edge_det;
    logic [NUM_LINES-1:0] hw_set;
    logic [NUM_LINES-1:0] set_bits;
    logic [NUM_LINES-1:0] clr_bits;
    logic [NUM_LINES-1:0] capture_mask;
    logic [ID_W-1:0]      top_id;
    logic                 any_pending;
    logic                 unused_wdata;

    assign access       = PSEL & PENABLE;
    assign reg_sel      = decode_reg(32'(PADDR));
    assign wdata        = PWDATA[NUM_LINES-1:0];
    assign unused_wdata = ^PWDATA;

    // SET/CLEAR are write-only, ACK is read-only; anything else off-map is an error.
    always_comb begin
        bad_access = 1'b0;
        case (reg_sel)
            REG_NONE:           bad_access = 1'b1;
            REG_SET, REG_CLEAR: bad_access = ~PWRITE;
            REG_ACK:            bad_access = PWRITE;
            default:            bad_access = 1'b0;
        endcase
    end

    assign wr_en    = access & PWRITE & ~bad_access;
    assign rd_en    = access & ~PWRITE & ~bad_access;
    assign ack_read = rd_en & (reg_sel == REG_ACK) & (state_q == ST_SERVING);

    assign PREADY  = 1'b1;
    assign PSLVERR = access & bad_access & ~HRESET;

    always_comb begin
        ack_word = '0;
        if (state_q == ST_SERVING) begin
            ack_word[ACK_VLD_BIT] = 1'b1;
            ack_word[ID_W-1:0]    = ack_id_q;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en && !HRESET) begin
            case (reg_sel)
                REG_ENABLE:  rdata = 32'(enable_q);
                REG_PENDING: rdata = 32'(pending_q);
                REG_ACK:     rdata = ack_word;
                REG_MODE:    rdata = 32'(mode_q);
                default:     rdata = '0;
            endcase
        end
    end

    assign PRDATA = rdata;

    assign edge_det = signal_i & ~sig_q;
    assign hw_set   = enable_q & ((mode_q & edge_det) | (~mode_q & signal_i));
    assign set_bits = (wr_en && reg_sel == REG_SET)   ? wdata : '0;
    assign clr_bits = (wr_en && reg_sel == REG_CLEAR) ? wdata : '0;

    psu_prio_encoder #(
        .NUM_LINES (NUM_LINES),
        .ID_W      (ID_W)
    ) u_prio (
        .req_i   (pending_q),
        .id_o    (top_id),
        .valid_o (any_pending)
    );

    // The line handed to ACK leaves PENDING in the same cycle it is captured.
    assign capture_mask = (state_q == ST_IDLE && any_pending) ?
                          (NUM_LINES'(1) << top_id) : '0;

    always_comb begin
        if (wr_en && reg_sel == REG_PENDING) begin
            pending_d = wdata;
        end else begin
            pending_d = ((pending_q | hw_set | set_bits) & ~clr_bits) & ~capture_mask;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            sig_q     <= '0;
        end else begin
            sig_q     <= signal_i;
            pending_q <= pending_d;
            if (wr_en && reg_sel == REG_ENABLE) begin
                enable_q <= wdata;
            end
            if (wr_en && reg_sel == REG_MODE) begin
                mode_q <= wdata;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            ack_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pending) begin
                        state_q  <= ST_SERVING;
                        ack_id_q <= top_id;
                    end
                end
                ST_SERVING: begin
                    if (ack_read) begin
                        state_q  <= ST_IDLE;
                        ack_id_q <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ack_id_q <= '0;
                end
            endcase
        end
    end

    assign irq_o = (|pending_q) | (state_q == ST_SERVING);

endmodule

// File: tb/tb_param_service_unit.sv
// Self-checking bench for param_service_unit (8 lines): directed scenarios plus randomized APB/line traffic.
module tb_param_service_unit;

    localparam int NL = 8;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [NL-1:0] signal_i = '0;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    logic [NL-1:0] sig_next = '0;

    // Reference state: what software would see in each register.
    logic [NL-1:0] m_en, m_pend, m_mode, m_sig;
    bit            m_serv;
    int            m_id;

    always #10 HCLK = ~HCLK;

    param_service_unit #(
        .APB_ADDR_WIDTH (12),
        .NUM_LINES      (NL),
        .ID_W           (3)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .signal_i (signal_i),
        .irq_o    (irq_o)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // 0 ENABLE, 1 PENDING, 2 ACK, 3 MODE, 4 SET, 5 CLEAR, -1 unmapped
    function automatic int reg_kind(input logic [11:0] a);
        case (a)
            12'h000: return 0;
            12'h004: return 1;
            12'h008: return 2;
            12'h00C: return 3;
            12'h010: return 4;
            12'h014: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic bit m_err();
        int k;
        k = reg_kind(PADDR);
        if (!(PSEL && PENABLE)) return 1'b0;
        if (k < 0) return 1'b1;
        if (!PWRITE && k >= 4) return 1'b1;
        if (PWRITE && k == 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (HRESET || !(PSEL && PENABLE) || PWRITE || m_err()) return 32'h0;
        case (reg_kind(PADDR))
            0: return {24'h0, m_en};
            1: return {24'h0, m_pend};
            2: return m_serv ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
            3: return {24'h0, m_mode};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_mode = '0; m_sig = '0; m_serv = 1'b0; m_id = 0;
    endtask

    // Advance the reference by one clock using the inputs that were present during the cycle.
    task automatic model_step();
        logic [NL-1:0] hw, setb, clrb, np;
        bit wr, rd, rose;
        int k, hi;
        if (HRESET) begin
            model_reset();
            return;
        end
        k  = reg_kind(PADDR);
        wr = PSEL && PENABLE && PWRITE && !m_err();
        rd = PSEL && PENABLE && !PWRITE && !m_err();
        hw = '0;
        for (int i = 0; i < NL; i++) begin
            rose = signal_i[i] && !m_sig[i];
            if (m_en[i] && (m_mode[i] ? rose : signal_i[i])) hw[i] = 1'b1;
        end
        setb = (wr && k == 4) ? PWDATA[NL-1:0] : '0;
        clrb = (wr && k == 5) ? PWDATA[NL-1:0] : '0;
        hi = -1;
        if (!m_serv) begin
            for (int i = 0; i < NL; i++) if (m_pend[i]) hi = i;
        end
        if (wr && k == 1) begin
            np = PWDATA[NL-1:0];
        end else begin
            np = (m_pend | hw | setb) & ~clrb;
            if (hi >= 0) np[hi] = 1'b0;
        end
        if (hi >= 0) begin
            m_serv = 1'b1;
            m_id   = hi;
        end else if (m_serv && rd && k == 2) begin
            m_serv = 1'b0;
        end
        if (wr && k == 0) m_en = PWDATA[NL-1:0];
        if (wr && k == 3) m_mode = PWDATA[NL-1:0];
        m_sig  = signal_i;
        m_pend = np;
    endtask

    // Every cycle, away from the active edge, all outputs must match the reference.
    always @(negedge HCLK) begin
        check("irq_o", {31'h0, irq_o}, {31'h0, (m_pend != 0) || m_serv});
        check("PRDATA", PRDATA, m_rdata());
        check("PSLVERR", {31'h0, PSLVERR}, {31'h0, m_err() && !HRESET});
        check("PREADY", {31'h0, PREADY}, 32'h1);
    end

    task automatic cyc();
        @(posedge HCLK);
        model_step();
        #2;
        signal_i = sig_next;
    endtask

    task automatic apb_idle(input int n);
        repeat (n) begin
            cyc();
            PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        cyc();
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        cyc();
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a; PWDATA = '0;
        @(negedge HCLK);
        d = PRDATA;
        e = PSLVERR;
    endtask

    logic [11:0] addr_tab [8] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                  12'h010, 12'h014, 12'h018, 12'h3F0};

    initial begin
        logic [31:0] d;
        logic        e;
        model_reset();
        repeat (2) cyc();
        HRESET = 1'b0;

        // Reset state
        apb_rd(12'h000, d, e); check("rst_enable", d, 32'h0);
        apb_rd(12'h004, d, e); check("rst_pending", d, 32'h0);
        apb_rd(12'h00C, d, e); check("rst_mode", d, 32'h0);
        apb_rd(12'h008, d, e); check("rst_ack", d, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);

        // Single edge on line 3
        apb_wr(12'h000, 32'hFF);
        apb_wr(12'h00C, 32'hFF);
        sig_next = 8'h08; apb_idle(1);
        sig_next = 8'h00;
        apb_rd(12'h004, d, e); check("edge_pending_t1", d, 32'h08);
        apb_rd(12'h008, d, e); check("edge_ack_t2", d, 32'h8000_0003);
        apb_rd(12'h004, d, e); check("edge_pending_after", d, 32'h0);
        check("edge_irq_after", {31'h0, irq_o}, 32'h0);

        // Lines 2 and 6 together: highest first
        sig_next = 8'h44; apb_idle(1);
        sig_next = 8'h00; apb_idle(1);
        apb_rd(12'h008, d, e); check("dual_ack1", d, 32'h8000_0006);
        apb_idle(1);
        apb_rd(12'h008, d, e); check("dual_ack2", d, 32'h8000_0002);
        apb_idle(1);
        apb_rd(12'h008, d, e); check("dual_ack3", d, 32'h0);

        // Level mode, line 1 held
        apb_wr(12'h00C, 32'h00);
        sig_next = 8'h02; apb_idle(4);
        apb_rd(12'h008, d, e); check("level_ack", d, 32'h8000_0001);
        apb_idle(2);
        apb_rd(12'h004, d, e); check("level_reset_pending", d, 32'h02);
        sig_next = 8'h00; apb_idle(1);
        apb_rd(12'h008, d, e); check("level_ack_b", d, 32'h8000_0001);
        apb_idle(1);
        apb_rd(12'h008, d, e); check("level_ack_c", d, 32'h8000_0001);
        apb_idle(1);
        @(negedge HCLK);
        check("level_irq_released", {31'h0, irq_o}, 32'h0);

        // CLEAR beats an active hw_set; PENDING write beats hw_set
        sig_next = 8'h10; apb_wr(12'h014, 32'h10);
        sig_next = 8'h00;
        apb_rd(12'h004, d, e); check("clear_wins", d, 32'h0);
        sig_next = 8'h80; apb_wr(12'h004, 32'h05);
        sig_next = 8'h00;
        apb_rd(12'h004, d, e); check("pending_write_wins", d, 32'h05);

        // Unmapped offset
        apb_rd(12'h018, d, e);
        check("unmapped_prdata", d, 32'h0);
        check("unmapped_slverr", {31'h0, e}, 32'h1);

        // Asynchronous reset while SERVING with PENDING=0x3
        apb_wr(12'h004, 32'h03);
        apb_idle(1);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h004;
        #1;
        check("pre_rst_pending", PRDATA, 32'h03);
        check("pre_rst_irq", {31'h0, irq_o}, 32'h1);
        HRESET = 1'b1;
        model_reset();
        #1;
        check("async_rst_irq", {31'h0, irq_o}, 32'h0);
        check("async_rst_prdata", PRDATA, 32'h0);
        PADDR = 12'h018;
        #1;
        check("async_rst_slverr", {31'h0, PSLVERR}, 32'h0);
        cyc();
        HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        apb_rd(12'h004, d, e); check("post_rst_pending", d, 32'h0);
        apb_rd(12'h000, d, e); check("post_rst_enable", d, 32'h0);
        apb_rd(12'h008, d, e); check("post_rst_ack", d, 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            sig_next = NL'($urandom & $urandom & $urandom);
            cyc();
            PSEL    = ($urandom % 4) != 0;
            PENABLE = ($urandom % 3) != 0;
            PWRITE  = ($urandom % 2) != 0;
            PADDR   = addr_tab[$urandom % 8];
            PWDATA  = $urandom;
        end
        apb_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
